led_chaser_multi: RTL and testbench
===================================

Name: led_chaser_multi

Overview:
Parametrised LED pattern generator for the board LED bank. Drives N_LED outputs from one system clock through a programmable prescaler. Supports four run-time selectable patterns: rotate left, rotate right, ping-pong, fill/drain. Also provides pause, a speed select and a per-step strobe for other blocks that follow the display.

Parameters:
N_LED, 8, number of LED outputs (legal range 2..32)
DIV_BASE, 200_000, clocks per pattern step at speed=0 (must be >=1)
CNT_W, 25, prescaler counter width; must hold (DIV_BASE<<3)-1
ACTIVE_LOW, 1, 1: led = ~pat (board LEDs are low-active); 0: led = pat

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  1: prescaler and pattern advance; 0: freeze cnt, pat, phase
mode  in  2  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill/drain
speed  in  2  step period P = DIV_BASE << speed clocks
led  out  N_LED  pattern output, polarity per ACTIVE_LOW
step  out  1  one-cycle pulse, high in the first cycle a new pattern is on led

Behaviour:
- Internal registers: cnt[CNT_W-1:0], pat[N_LED-1:0], dir (0 up / 1 down), phase (0 FILL / 1 DRAIN), mode_q[1:0], step.
- Reset (rst=1 at edge): cnt=0, pat=1 (bit0 only), dir=0, phase=0, step=0, mode_q=mode.
  - led after reset = ~1 (all ones except bit0 low) when ACTIVE_LOW=1; 1 when ACTIVE_LOW=0.
  - rst overrides en, mode and tick in the same cycle. Mid-run reset restarts the pattern from bit0 on the next edge.
- Prescaler: when en=1, tick = (cnt >= P-1).
  - On tick: cnt<=0. Otherwise cnt<=cnt+1.
  - Using >= makes a speed decrease take effect immediately: a stale larger cnt ticks on the next cycle.
  - en=0: cnt holds and no tick.
- Mode change: if mode != mode_q, the next edge does mode_q<=mode, pat<=1, dir<=0, phase<=0, cnt<=0, step<=0. This resync has priority over tick.
- Pattern update on tick (mode_q unchanged), with step<=1 in the same edge. In all other cycles step<=0.
  - 00 rotate-left: pat <= {pat[N-2:0], pat[N-1]}. MSB wraps to bit0 in one step; no extra dwell at the MSB.
  - 01 rotate-right: pat <= {pat[0], pat[N-1:1]}.
  - 10 ping-pong, dir=0: if pat[N-1], then dir<=1 and pat<=pat>>1; else pat<=pat<<1.
  - 10 ping-pong, dir=1: if pat[0], then dir<=0 and pat<=pat<<1; else pat<=pat>>1.
  - Ping-pong cycle length is 2N-2 steps. The end LEDs are lit for one step only.
  - 11 FILL (phase=0): pat <= {pat[N-2:0],1'b1}. If pat is already all ones: phase<=1 and pat<=pat<<1.
  - 11 DRAIN (phase=1): pat <= pat<<1. If pat==0: phase<=0 and pat<=1.
  - Fill/drain cycle for N=8 is 16 steps: 01,03,..,FF,FE,FC,..,80,00,01.
- led is combinational from pat only (no glitch path from cnt). step is registered.
- Latency: first step occurs P clocks after reset release with en=1 held.
- en deasserted on a tick cycle suppresses that tick. Re-asserting en resumes from the held cnt.

Test Plan:
- DIV_BASE=4, N_LED=8, ACTIVE_LOW=0, mode=00, speed=0, en=1, release rst -> led 01 for 4 clocks, then 02; step pulses every 4 clocks. After 80 the next value is 01. 8 steps return to 01.
- mode=10 from reset -> led 01,02,..,80,40,..,02,01,02. Bounce at 80 and 01 takes one step each; period is 14 steps.
- mode=11 -> 01,03,07,..,FF,FE,FC,..,80,00,01. Exactly 16 steps per cycle; phase flips at FF and at 00.
- speed=3 for 2 steps, then speed=0 with cnt>3 -> tick on the very next clock, then steady 4-clock period. With speed=1 the measured period is 8 clocks.
- Change mode 00->01 mid-run at led=10 -> next edge led=01, cnt=0, step=0. Subsequent sequence is 80,40,.. every 4 clocks.
- en=0 for 10 clocks mid-period, then rst=1 for 1 cycle during a run with ACTIVE_LOW=1 -> led frozen while en=0. After rst, led=FE, step=0, and the first step comes 4 clocks after rst falls.

Source files
------------

// File: rtl/led_chaser_multi.sv
// LED bank pattern generator: rotate, ping-pong and fill/drain
// patterns advanced by a speed-selectable prescaler.
module led_chaser_multi #(
  parameter int N_LED      = 8,
  parameter int DIV_BASE   = 200_000,
  parameter int CNT_W      = 25,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             step
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(DIV_BASE);
  localparam logic [N_LED-1:0] ONE  = N_LED'(1);

  logic [CNT_W-1:0] cnt, cnt_d, per_m1;
  logic [N_LED-1:0] pat, pat_d;
  logic             dir, dir_d;
  logic             phase, phase_d;
  logic             step_d;
  logic [1:0]       mode_q;
  logic             tick;

  // >= lets a speed decrease take effect on the next clock
  assign per_m1 = (BASE << speed) - CNT_W'(1);
  assign tick   = en && (cnt >= per_m1);

  always_comb begin
    cnt_d   = cnt;
    pat_d   = pat;
    dir_d   = dir;
    phase_d = phase;
    step_d  = 1'b0;
    if (mode != mode_q) begin
      cnt_d   = '0;
      pat_d   = ONE;
      dir_d   = 1'b0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      unique case (mode_q)
        2'b00: pat_d = {pat[N_LED-2:0], pat[N_LED-1]};
        2'b01: pat_d = {pat[0], pat[N_LED-1:1]};
        2'b10: begin
          if (!dir) begin
            if (pat[N_LED-1]) begin
              dir_d = 1'b1;
              pat_d = pat >> 1;
            end else begin
              pat_d = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              dir_d = 1'b0;
              pat_d = pat << 1;
            end else begin
              pat_d = pat >> 1;
            end
          end
        end
        2'b11: begin
          if (!phase) begin
            if (&pat) begin
              phase_d = 1'b1;
              pat_d   = pat << 1;
            end else begin
              pat_d = {pat[N_LED-2:0], 1'b1};
            end
          end else begin
            if (pat == '0) begin
              phase_d = 1'b0;
              pat_d   = ONE;
            end else begin
              pat_d = pat << 1;
            end
          end
        end
      endcase
    end else if (en) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      pat    <= ONE;
      dir    <= 1'b0;
      phase  <= 1'b0;
      step   <= 1'b0;
      mode_q <= mode;
    end else begin
      cnt    <= cnt_d;
      pat    <= pat_d;
      dir    <= dir_d;
      phase  <= phase_d;
      step   <= step_d;
      mode_q <= mode;
    end
  end

  assign led = ACTIVE_LOW ? ~pat : pat;

endmodule

// File: tb/tb_led_chaser_multi.sv
// Bench for led_chaser_multi: randomized runs against a
// step-index reference model, checked via a scoreboard queue.
module tb_led_chaser_multi;

  localparam int N  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [1:0]   speed = 2'b00;
  logic [N-1:0] led, led_n;
  logic         step, step_n;

  led_chaser_multi #(
    .N_LED(N), .DIV_BASE(DB), .CNT_W(8), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .speed(speed), .led(led), .step(step)
  );

  led_chaser_multi #(
    .N_LED(N), .DIV_BASE(DB), .CNT_W(8), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .speed(speed), .led(led_n), .step(step_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] led;
    logic         step;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  int       m_k = 0;
  int       m_acc = 0;
  logic [1:0] m_mq = 2'b00;

  // Pattern after k steps of a given mode, from closed-form rules
  function automatic logic [N-1:0] pat_of(logic [1:0] m, int k);
    int j;
    int v;
    v = 0;
    unique case (m)
      2'b00: v = 1 << (k % N);
      2'b01: v = 1 << ((N - (k % N)) % N);
      2'b10: begin
        j = k % (2*N - 2);
        v = (j < N) ? (1 << j) : (1 << (2*N - 2 - j));
      end
      2'b11: begin
        j = k % (2*N);
        if (j < N)             v = (1 << (j + 1)) - 1;
        else if (j < 2*N - 1)  v = ((1 << N) - 1) << (j - N + 1);
        else                   v = 0;
      end
    endcase
    return v[N-1:0];
  endfunction

  task automatic drive(input logic r, input logic e,
                       input logic [1:0] md,
                       input logic [1:0] sp);
    exp_t x;
    int   per;
    @(negedge clk);
    rst = r;
    en = e;
    mode = md;
    speed = sp;
    x.step = 1'b0;
    per = DB << sp;
    if (r || md != m_mq) begin
      m_k = 0;
      m_acc = 0;
      m_mq = md;
    end else if (e) begin
      if (m_acc + 1 >= per) begin
        m_k++;
        m_acc = 0;
        x.step = 1'b1;
      end else begin
        m_acc++;
      end
    end
    x.led = pat_of(m_mq, m_k);
    q.push_back(x);
  endtask

  task automatic run(input int n, input logic r, input logic e,
                     input logic [1:0] md, input logic [1:0] sp);
    for (int i = 0; i < n; i++) drive(r, e, md, sp);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (led !== x.led) begin
          bad++;
          $display("FAIL led t=%0t got=%h want=%h", $time, led, x.led);
        end
        total++;
        if (step !== x.step) begin
          bad++;
          $display("FAIL step t=%0t got=%b want=%b", $time, step, x.step);
        end
        total++;
        if (led_n !== ~x.led || step_n !== x.step) begin
          bad++;
          $display("FAIL led_low t=%0t got=%h/%b want=%h/%b",
                   $time, led_n, step_n, ~x.led, x.step);
        end
      end
    end
  end

  initial begin : stim
    logic [1:0] md;
    logic [1:0] sp;
    int         len;
    run(2, 1'b1, 1'b1, 2'b00, 2'b00);
    run(40, 1'b0, 1'b1, 2'b00, 2'b00);
    run(1, 1'b1, 1'b1, 2'b10, 2'b00);
    run(70, 1'b0, 1'b1, 2'b10, 2'b00);
    run(80, 1'b0, 1'b1, 2'b11, 2'b00);
    run(70, 1'b0, 1'b1, 2'b00, 2'b11);
    run(20, 1'b0, 1'b1, 2'b00, 2'b00);
    run(40, 1'b0, 1'b1, 2'b00, 2'b01);
    run(1, 1'b1, 1'b1, 2'b00, 2'b00);
    run(16, 1'b0, 1'b1, 2'b00, 2'b00);
    run(20, 1'b0, 1'b1, 2'b01, 2'b00);
    run(2, 1'b0, 1'b1, 2'b01, 2'b00);
    run(10, 1'b0, 1'b0, 2'b01, 2'b00);
    run(3, 1'b0, 1'b1, 2'b01, 2'b00);
    run(1, 1'b1, 1'b1, 2'b01, 2'b00);
    run(20, 1'b0, 1'b1, 2'b01, 2'b00);
    md = 2'b01;
    for (int s = 0; s < 80; s++) begin
      if ($urandom % 2 == 0) md = 2'($urandom);
      sp = 2'($urandom_range(0, 2));
      len = $urandom_range(4, 60);
      if ($urandom % 10 == 0) drive(1'b1, 1'b1, md, sp);
      for (int c = 0; c < len; c++)
        drive(1'b0, ($urandom % 8) != 0, md, sp);
    end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
